icmp_pipe_op: RTL
=================

// Module: icmp_pipe_op
// PURPOSE
//   Pipelined integer compare op. Produces the 1-bit 'cond' consumed by the
//   select op one stage downstream. An aligned sideband payload (typically the
//   select's true/false operands) travels with each compare so that cond and
//   operands reach the select in the same cycle. Stalls with the global
//   'enable', the same way as the other ops in the library.
// PARAMETERS
//   ParamOpCode       "eq"  predicate: eq ne ugt uge ult ule sgt sge slt sle
//   ParamBitWidth     32    width of lhs/rhs (1..64)
//   ParamLatency      2     pipeline depth in enabled cycles (1..4)
//   ParamPayloadWidth 64    width of aligned sideband payload (1..256)
// PORTS
//   clk          in   1                  clock, rising edge
//   rst_n        in   1                  async reset, active low
//   enable       in   1                  1 = pipeline advances; 0 = hold all state
//   in_valid     in   1                  lhs/rhs/payload_in valid this cycle
//   lhs          in   ParamBitWidth      left operand
//   rhs          in   ParamBitWidth      right operand
//   payload_in   in   ParamPayloadWidth  sideband data to delay alongside compare
//   out_valid    out  1                  cond/payload_out hold a new result
//   cond         out  1                  compare result (1 = predicate true)
//   payload_out  out  ParamPayloadWidth  payload_in delayed by ParamLatency
// BEHAVIOUR
//   - Reset (rst_n=0, async assert, sync release): all stage valid bits,
//     cond, payload_out and internal data regs = 0; out_valid = 0.
//   - Stage 1 registers lhs, rhs, payload_in and in_valid when enable=1.
//     Compare is evaluated on stage-1 registered operands. The result and the
//     payload then pass through ParamLatency-1 further stages; for
//     ParamLatency=1 the stage-1 regs hold the result directly.
//   - Latency: result for inputs sampled at enabled edge N appears on
//     cond/out_valid after enabled edge N+ParamLatency-1. Disabled cycles do
//     not count.
//   - Each stage k: v[k] <= v[k-1] when enable=1. Data regs of stage k load
//     only when enable=1 && v[k-1]=1. Bubbles therefore leave data unchanged.
//   - enable=0: every reg, including out_valid, holds. No valid is dropped or
//     duplicated. out_valid may stay 1 across the stall; the consumer also
//     stalls on enable.
//   - out_valid=0: cond/payload_out hold the last valid result (0 after reset).
//   - Unsigned predicates (u*, eq, ne) use raw bits. s* predicates use
//     $signed two's complement at ParamBitWidth.
//   - The result is exactly 1 bit. No carry out or overflow is exposed.
//   - Illegal ParamOpCode or out-of-range parameters are an elaboration-time
//     $error, not a runtime default.
//   - Back-to-back valid inputs sustain 1 result per enabled cycle.
//   - No FSM. Control is the ParamLatency-deep valid shift register. No
//     handshake beyond enable.
//   - Reset mid-operation: all in-flight results are discarded at once.
//     out_valid goes to 0 in the same cycle as rst_n falls.
// TESTING
//   1 Reset: rst_n=0 while in_valid=1 and enable=1 -> out_valid=0, cond=0,
//     payload_out=0 throughout reset and for ParamLatency cycles after release.
//   2 "slt", W=8, Lat=2: lhs=8'hFF, rhs=8'h01, payload=64'hA5 -> 2 edges later
//     out_valid=1, cond=1, payload_out=64'hA5. Same operands with "ult" -> cond=0.
//   3 Streaming "eq": 6 back-to-back pairs (3,3)(3,4)(0,0)(FF,FF)(1,2)(7,7)
//     -> cond sequence 1,0,1,1,0,1 on 6 consecutive cycles with out_valid=1.
//   4 Stall: stream 3 values, drop enable for 5 cycles mid-flight -> outputs
//     frozen during the stall, then identical sequence resumes with no loss or
//     duplication.
//   5 Bubbles: in_valid pattern 1,0,0,1 -> out_valid pattern 1,0,0,1 delayed
//     by the latency. cond/payload_out hold the first result during the gap.
//   6 Boundaries "sge"/"ule", W=32: (32'h80000000,32'h7FFFFFFF) -> sge cond=0,
//     ule cond=0. Equal operands -> both 1. Repeat for Lat=1 and Lat=4.

Source files
------------

// File: rtl/icmp_pipe_op.sv
// rtl/icmp_pipe_op.sv - pipelined integer compare with aligned sideband payload
module icmp_pipe_op #(
    parameter string ParamOpCode       = "eq",
    parameter int    ParamBitWidth     = 32,
    parameter int    ParamLatency      = 2,
    parameter int    ParamPayloadWidth = 64
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         enable,
    input  logic                         in_valid,
    input  logic [ParamBitWidth-1:0]     lhs,
    input  logic [ParamBitWidth-1:0]     rhs,
    input  logic [ParamPayloadWidth-1:0] payload_in,
    output logic                         out_valid,
    output logic                         cond,
    output logic [ParamPayloadWidth-1:0] payload_out
);

    // Predicate decoded once at elaboration; -1 marks an unknown opcode.
    localparam int OpSel = (ParamOpCode == "eq")  ? 0 :
                           (ParamOpCode == "ne")  ? 1 :
                           (ParamOpCode == "ugt") ? 2 :
                           (ParamOpCode == "uge") ? 3 :
                           (ParamOpCode == "ult") ? 4 :
                           (ParamOpCode == "ule") ? 5 :
                           (ParamOpCode == "sgt") ? 6 :
                           (ParamOpCode == "sge") ? 7 :
                           (ParamOpCode == "slt") ? 8 :
                           (ParamOpCode == "sle") ? 9 : -1;

    // With a single stage the compare result itself is the stage-1 register,
    // so cond reads 0 out of reset rather than the compare of zeroed operands.
    localparam int CondLo = (ParamLatency == 1) ? 1 : 2;

    if (OpSel < 0) begin : g_err_op
        $error("icmp_pipe_op: illegal ParamOpCode %s", ParamOpCode);
    end
    if (ParamBitWidth < 1 || ParamBitWidth > 64) begin : g_err_width
        $error("icmp_pipe_op: ParamBitWidth %0d outside 1..64", ParamBitWidth);
    end
    if (ParamLatency < 1 || ParamLatency > 4) begin : g_err_lat
        $error("icmp_pipe_op: ParamLatency %0d outside 1..4", ParamLatency);
    end
    if (ParamPayloadWidth < 1 || ParamPayloadWidth > 256) begin : g_err_pay
        $error("icmp_pipe_op: ParamPayloadWidth %0d outside 1..256", ParamPayloadWidth);
    end

    logic [ParamLatency:1]         r_v;
    logic [ParamPayloadWidth-1:0]  r_pay [1:ParamLatency];
    logic [ParamLatency:CondLo]    r_cond;

    logic [ParamLatency:0]         w_vchain;
    logic [ParamLatency:CondLo-1]  w_cchain;
    logic [ParamPayloadWidth-1:0]  w_pchain [0:ParamLatency];
    logic [ParamBitWidth-1:0]      w_a;
    logic [ParamBitWidth-1:0]      w_b;
    logic                          w_cmp;

    // Index k-1 of each chain is the source feeding stage k.
    assign w_vchain = {r_v, in_valid};
    assign w_cchain = {r_cond, w_cmp};

    if (ParamLatency == 1) begin : g_lat1
        assign w_a = lhs;
        assign w_b = rhs;
    end else begin : g_latn
        logic [ParamBitWidth-1:0] r_lhs;
        logic [ParamBitWidth-1:0] r_rhs;

        // Stage-1 operand capture; bubbles leave the previous operands in place.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_lhs <= '0;
                r_rhs <= '0;
            end else if (enable && in_valid) begin
                r_lhs <= lhs;
                r_rhs <= rhs;
            end
        end

        assign w_a = r_lhs;
        assign w_b = r_rhs;
    end

    // Predicate evaluation; signed forms reinterpret the raw bits as two's complement.
    always_comb begin
        w_cmp = 1'b0;
        case (OpSel)
            0:       w_cmp = (w_a == w_b);
            1:       w_cmp = (w_a != w_b);
            2:       w_cmp = (w_a >  w_b);
            3:       w_cmp = (w_a >= w_b);
            4:       w_cmp = (w_a <  w_b);
            5:       w_cmp = (w_a <= w_b);
            6:       w_cmp = ($signed(w_a) >  $signed(w_b));
            7:       w_cmp = ($signed(w_a) >= $signed(w_b));
            8:       w_cmp = ($signed(w_a) <  $signed(w_b));
            9:       w_cmp = ($signed(w_a) <= $signed(w_b));
            default: w_cmp = 1'b0;
        endcase
    end

    // Payload source chain: external input, then each stage's register.
    always_comb begin
        w_pchain[0] = payload_in;
        for (int k = 1; k <= ParamLatency; k++) begin
            w_pchain[k] = r_pay[k];
        end
    end

    // Valid shift register plus data stages that load only behind a valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_v    <= '0;
            r_cond <= '0;
            for (int k = 1; k <= ParamLatency; k++) begin
                r_pay[k] <= '0;
            end
        end else if (enable) begin
            for (int k = 1; k <= ParamLatency; k++) begin
                r_v[k] <= w_vchain[k-1];
                if (w_vchain[k-1]) begin
                    r_pay[k] <= w_pchain[k-1];
                end
            end
            for (int k = CondLo; k <= ParamLatency; k++) begin
                if (w_vchain[k-1]) begin
                    r_cond[k] <= w_cchain[k-1];
                end
            end
        end
    end

    assign out_valid   = r_v[ParamLatency];
    assign cond        = r_cond[ParamLatency];
    assign payload_out = w_pchain[ParamLatency];

endmodule
